// File: rtl/core_pkg.sv
`default_nettype none
// ==== core_pkg : types and constants shared by the pipeline stages (rev 1.0) ====
package core_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [0:0] {
    REQ  = 1'b0,
    HOLD = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } if_id_t;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ==== if_id_reg : stage register, freeze beats flush beats load, else bubble (rev 1.0) ====
module if_id_reg
  import core_pkg::*;
#(
  parameter logic [31:0] FLUSH_INSTR = core_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   freeze,
  input  logic   flush,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t reg_d, reg_q;

  always_comb begin
    reg_d = reg_q;
    if (!freeze) begin
      reg_d.valid    = 1'b0;
      reg_d.instr    = FLUSH_INSTR;
      reg_d.pc_plus4 = 32'h0;
      if (!flush && load) begin
        reg_d = d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q.valid    <= 1'b0;
      reg_q.instr    <= FLUSH_INSTR;
      reg_q.pc_plus4 <= 32'h0;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign q = reg_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ==== if_fetch_stage : PC, fetch FSM and skid buffer feeding the IF/ID register (rev 1.0) ====
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        condition,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] pc_out
);
  import core_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pend_q, pend_d;
  logic [31:0]  pend_tgt_q, pend_tgt_d;
  logic [31:0]  skid_instr_q, skid_instr_d;
  logic [31:0]  skid_pc4_q, skid_pc4_d;
  logic         started_q;

  logic         redir, fetching, rvalid, ifid_load;
  logic [31:0]  pc_plus4;
  if_id_t       ifid_d, ifid_q;

  assign redir    = condition & ~freeze;
  // No request goes out until the first edge after reset release.
  assign fetching = started_q & (state_q == REQ);
  assign rvalid   = fetching & imem_rvalid;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    pend_tgt_d   = pend_tgt_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    ifid_load    = 1'b0;
    ifid_d       = '{1'b1, imem_rdata, pc_plus4};
    if (state_q == REQ) begin
      if (rvalid && (pend_q || redir)) begin
        pc_d   = redir ? branch_target : pend_tgt_q;
        pend_d = 1'b0;
      end else if (rvalid && freeze) begin
        skid_instr_d = imem_rdata;
        skid_pc4_d   = pc_plus4;
        pc_d         = pc_plus4;
        state_d      = HOLD;
      end else if (rvalid) begin
        ifid_load = 1'b1;
        pc_d      = pc_plus4;
      end else if (redir) begin
        // Address must stay stable until the in-flight word returns.
        pend_d     = 1'b1;
        pend_tgt_d = branch_target;
      end
    end else begin
      if (redir) begin
        pc_d    = branch_target;
        state_d = REQ;
      end else if (!freeze) begin
        ifid_load = 1'b1;
        ifid_d    = '{1'b1, skid_instr_q, skid_pc4_q};
        state_d   = REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      pend_q       <= 1'b0;
      pend_tgt_q   <= 32'h0;
      skid_instr_q <= NOP_INSTR;
      skid_pc4_q   <= 32'h0;
      started_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      pend_tgt_q   <= pend_tgt_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      started_q    <= 1'b1;
    end
  end

  if_id_reg #(
    .FLUSH_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .freeze(freeze),
    .flush (redir),
    .load  (ifid_load),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign imem_req       = fetching;
  assign imem_addr      = pc_q;
  assign pc_out         = pc_q;
  assign if_id_valid    = ifid_q.valid;
  assign if_id_instr    = ifid_q.instr;
  assign if_id_pc_plus4 = ifid_q.pc_plus4;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ==== tb_if_fetch_stage : directed scenarios plus randomized program-order check (rev 1.0) ====
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze;
  logic        condition;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] pc_out;

  int errors = 0;
  int checks = 0;

  // Memory responder: word at address A reads as A+0x100.
  int          mem_lat  = 0;
  bit          mem_rand = 1'b0;
  bit          busy     = 1'b0;
  int          mem_wait = 0;
  logic [31:0] req_addr = 32'h0;
  bit          addr_moved = 1'b0;

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .freeze        (freeze),
    .condition     (condition),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4),
    .pc_out        (pc_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        = 1'b0;
      mem_wait    = 0;
      imem_rvalid = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      if (imem_req) begin
        if (!busy) begin
          busy     = 1'b1;
          mem_wait = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
          req_addr = imem_addr;
        end else if (imem_addr !== req_addr) begin
          addr_moved = 1'b1;
        end
        if (mem_wait == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = imem_addr + 32'h100;
          busy        = 1'b0;
        end else begin
          mem_wait = mem_wait - 1;
        end
      end else if (busy) begin
        addr_moved = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves IF/ID holding the word at 0 and the PC at 4.
  task automatic do_reset();
    mem_lat = 0; mem_rand = 1'b0;
    freeze = 1'b0; condition = 1'b0; branch_target = 32'h0;
    rst_n = 1'b0;
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset();
    freeze = 1'b0; condition = 1'b0; branch_target = 32'h0; imem_rdata = 32'h0;
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
    checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", if_id_instr); end
    checks++; if (if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got=%h exp=0", if_id_pc_plus4); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req got=%b/%h exp=1/0", imem_req, imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL early_valid got=%b exp=0", if_id_valid); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h100 || if_id_pc_plus4 !== 32'h4)
      begin errors++; $display("FAIL first_instr got=%b/%h/%h exp=1/100/4", if_id_valid, if_id_instr, if_id_pc_plus4); end
  endtask

  task automatic test_stream();
    logic [31:0] a;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      a = 32'(k * 4);
      checks++; if (imem_addr !== a) begin errors++; $display("FAIL stream_addr got=%h exp=%h", imem_addr, a); end
      tick();
      checks++; if (if_id_valid !== 1'b1 || if_id_instr !== a + 32'h100 || if_id_pc_plus4 !== a + 32'h4)
        begin errors++; $display("FAIL stream_instr got=%b/%h/%h exp=1/%h/%h", if_id_valid, if_id_instr, if_id_pc_plus4, a + 32'h100, a + 32'h4); end
    end
  endtask

  task automatic test_branch();
    do_reset();
    tick(); tick(); tick();
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL br_setup got=%h exp=10", imem_addr); end
    condition = 1'b1; branch_target = 32'h40;
    tick();
    condition = 1'b0;
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc_plus4 !== 32'h0)
      begin errors++; $display("FAIL br_bubble got=%b/%h/%h exp=0/0/0", if_id_valid, if_id_instr, if_id_pc_plus4); end
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL br_addr got=%h exp=40", imem_addr); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h140 || if_id_pc_plus4 !== 32'h44)
      begin errors++; $display("FAIL br_target got=%b/%h/%h exp=1/140/44", if_id_valid, if_id_instr, if_id_pc_plus4); end
  endtask

  task automatic test_freeze();
    do_reset();
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h100 || if_id_pc_plus4 !== 32'h4)
        begin errors++; $display("FAIL frz_hold got=%b/%h/%h exp=1/100/4", if_id_valid, if_id_instr, if_id_pc_plus4); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL frz_req got=%b exp=0", imem_req); end
    end
    freeze = 1'b0;
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h104 || if_id_pc_plus4 !== 32'h8)
      begin errors++; $display("FAIL frz_release got=%b/%h/%h exp=1/104/8", if_id_valid, if_id_instr, if_id_pc_plus4); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL frz_resume got=%b/%h exp=1/8", imem_req, imem_addr); end
    tick();
    checks++; if (if_id_instr !== 32'h108 || if_id_pc_plus4 !== 32'hC)
      begin errors++; $display("FAIL frz_next got=%h/%h exp=108/c", if_id_instr, if_id_pc_plus4); end
  endtask

  task automatic test_latency_redirect();
    do_reset();
    mem_lat = 3;
    condition = 1'b1; branch_target = 32'h80;
    tick();
    condition = 1'b0;
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL lat_flush got=%b exp=0", if_id_valid); end
    for (int k = 0; k < 2; k++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL lat_stable got=%b/%h exp=1/4", imem_req, imem_addr); end
      tick();
    end
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL lat_stable_last got=%h exp=4", imem_addr); end
    tick();
    checks++; if (imem_addr !== 32'h80 || if_id_valid !== 1'b0)
      begin errors++; $display("FAIL lat_discard got=%h/%b exp=80/0", imem_addr, if_id_valid); end
    mem_lat = 0;
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h180 || if_id_pc_plus4 !== 32'h84)
      begin errors++; $display("FAIL lat_target got=%b/%h/%h exp=1/180/84", if_id_valid, if_id_instr, if_id_pc_plus4); end
  endtask

  task automatic test_freeze_condition();
    do_reset();
    freeze = 1'b1; condition = 1'b1; branch_target = 32'h200;
    tick();
    checks++; if (pc_out !== 32'h8 || if_id_instr !== 32'h100)
      begin errors++; $display("FAIL fc_ignore got=%h/%h exp=8/100", pc_out, if_id_instr); end
    tick();
    checks++; if (pc_out !== 32'h8 || imem_req !== 1'b0)
      begin errors++; $display("FAIL fc_hold got=%h/%b exp=8/0", pc_out, imem_req); end
    freeze = 1'b0;
    tick();
    condition = 1'b0;
    checks++; if (imem_addr !== 32'h200 || if_id_valid !== 1'b0)
      begin errors++; $display("FAIL fc_redirect got=%h/%b exp=200/0", imem_addr, if_id_valid); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h300 || if_id_pc_plus4 !== 32'h204)
      begin errors++; $display("FAIL fc_target got=%b/%h/%h exp=1/300/204", if_id_valid, if_id_instr, if_id_pc_plus4); end
  endtask

  task automatic test_reset_mid_wait_and_wrap();
    do_reset();
    mem_lat = 3;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc_plus4 !== 32'h0 || pc_out !== 32'h0)
      begin errors++; $display("FAIL async_rst got=%b/%b/%h/%h/%h exp=0/0/0/0/0", imem_req, if_id_valid, if_id_instr, if_id_pc_plus4, pc_out); end
    mem_lat = 0;
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h100 || imem_addr !== 32'h4)
      begin errors++; $display("FAIL restart got=%b/%h/%h exp=1/100/4", if_id_valid, if_id_instr, imem_addr); end
    condition = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    condition = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
    tick();
    checks++; if (if_id_instr !== 32'h0000_00FC || if_id_pc_plus4 !== 32'h0 || imem_addr !== 32'h0)
      begin errors++; $display("FAIL wrap got=%h/%h/%h exp=fc/0/0", if_id_instr, if_id_pc_plus4, imem_addr); end
    tick();
    checks++; if (if_id_instr !== 32'h100 || if_id_pc_plus4 !== 32'h4)
      begin errors++; $display("FAIL wrap_next got=%h/%h exp=100/4", if_id_instr, if_id_pc_plus4); end
  endtask

  // Program-order model: every delivered word must follow the previous one
  // by 4, except that after a redirect the stream restarts at the target.
  task automatic test_random();
    logic [31:0] exp_next;
    logic        p_freeze, p_redir;
    logic [31:0] p_tgt;
    int          delivered;
    do_reset();
    mem_rand = 1'b1; addr_moved = 1'b0;
    exp_next = 32'h4; delivered = 0;
    for (int i = 0; i < 400; i++) begin
      freeze        = ($urandom_range(0, 3) == 0);
      condition     = ($urandom_range(0, 7) == 0);
      branch_target = $urandom & 32'hFFFF_FFFC;
      p_freeze = freeze; p_redir = condition & ~freeze; p_tgt = branch_target;
      tick();
      if (p_redir) begin
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rnd_flush cyc=%0d got=%b exp=0", i, if_id_valid); end
        exp_next = p_tgt;
      end else if (!p_freeze && if_id_valid === 1'b1) begin
        checks++; if (if_id_instr !== exp_next + 32'h100 || if_id_pc_plus4 !== exp_next + 32'h4)
          begin errors++; $display("FAIL rnd_order cyc=%0d got=%h/%h exp=%h/%h", i, if_id_instr, if_id_pc_plus4, exp_next + 32'h100, exp_next + 32'h4); end
        exp_next  = exp_next + 32'h4;
        delivered = delivered + 1;
      end
    end
    freeze = 1'b0; condition = 1'b0; mem_rand = 1'b0;
    checks++; if (addr_moved) begin errors++; $display("FAIL rnd_addr_stable got=moved exp=stable"); end
    checks++; if (delivered < 30) begin errors++; $display("FAIL rnd_progress got=%0d exp>=30", delivered); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_branch();
    test_freeze();
    test_latency_redirect();
    test_freeze_condition();
    test_reset_mid_wait_and_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
